// File: rtl/gtwiz_drp_rmw_switch_mc.sv
// Round-robin DRP read-modify-write of one masked field across NUM_CH transceiver channels.
// Writes are skipped when the field already matches; a stuck drprdy aborts with a per-channel error flag.
module gtwiz_drp_rmw_switch_mc #(
  parameter int                    NUM_CH          = 4,
  parameter int                    DRP_ADDR_W      = 10,
  parameter int                    DRP_DATA_W      = 16,
  parameter logic [DRP_ADDR_W-1:0] RMW_ADDR        = 10'h08A,
  parameter logic [DRP_DATA_W-1:0] RMW_MASK        = 16'h4000,
  parameter bit                    MODE_ACTIVE_LOW = 1'b1,
  parameter int                    TIMEOUT_CYC     = 1023
) (
  input  logic                         freerun_clk_in,
  input  logic                         gtwiz_drp_reset_in,
  input  logic [NUM_CH-1:0]            drp_reconfig_rdy_in,
  input  logic [NUM_CH-1:0]            mode_in,
  output logic [NUM_CH-1:0]            drp_reconfig_done_out,
  output logic [NUM_CH-1:0]            drp_err_out,
  output logic [NUM_CH-1:0]            drpen_out,
  output logic [NUM_CH-1:0]            drpwe_out,
  output logic [DRP_ADDR_W-1:0]        drpaddr_out,
  output logic [DRP_DATA_W-1:0]        drpdi_out,
  input  logic [NUM_CH-1:0]            drprdy_in,
  input  logic [NUM_CH*DRP_DATA_W-1:0] drpdo_in,
  output logic                         busy_out
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, START_RD, WAIT_RD, CHK, START_WR, WAIT_WR, FINISH
  } state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_sel_q, ch_sel_d;
  logic                  mode_sel_q, mode_sel_d;
  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DRP_DATA_W-1:0] data_q, data_d;
  logic                  tmo_q, tmo_d;
  logic [NUM_CH-1:0]     done_q, done_d;
  logic [NUM_CH-1:0]     err_q, err_d;
  logic [NUM_CH-1:0]     drpen_q, drpen_d;
  logic [NUM_CH-1:0]     drpwe_q, drpwe_d;
  logic [DRP_ADDR_W-1:0] drpaddr_q, drpaddr_d;
  logic [DRP_DATA_W-1:0] drpdi_q, drpdi_d;
  logic                  busy_q, busy_d;

  logic [NUM_CH-1:0]     elig;
  logic                  found;
  logic [CH_W-1:0]       grant_idx;
  logic [DRP_DATA_W-1:0] target;
  logic [DRP_DATA_W-1:0] rd_slice;
  logic [NUM_CH-1:0]     sel_oh;
  logic                  strobe_st;

  assign elig     = drp_reconfig_rdy_in & ~done_q;
  assign target   = (mode_sel_q ^ MODE_ACTIVE_LOW) ? RMW_MASK : '0;
  assign rd_slice = drpdo_in[int'(ch_sel_q)*DRP_DATA_W +: DRP_DATA_W];

  // First eligible channel at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    found     = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && elig[idx]) begin
        found     = 1'b1;
        grant_idx = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_sel_d   = ch_sel_q;
    mode_sel_d = mode_sel_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    // Completion flags clear as soon as the requester drops its level.
    done_d     = done_q & drp_reconfig_rdy_in;
    err_d      = err_q & drp_reconfig_rdy_in;

    case (state_q)
      IDLE: begin
        if (found) begin
          ch_sel_d   = grant_idx;
          mode_sel_d = mode_in[grant_idx];
          tmo_d      = 1'b0;
          state_d    = START_RD;
        end
      end
      START_RD: begin
        cnt_d   = '0;
        state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (drprdy_in[ch_sel_q]) begin
          data_d  = rd_slice;
          state_d = CHK;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CHK: begin
        if ((data_q & RMW_MASK) == target) begin
          state_d = FINISH;
        end else begin
          data_d  = (data_q & ~RMW_MASK) | target;
          state_d = START_WR;
        end
      end
      START_WR: begin
        cnt_d   = '0;
        state_d = WAIT_WR;
      end
      WAIT_WR: begin
        if (drprdy_in[ch_sel_q]) begin
          state_d = FINISH;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = FINISH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH: begin
        done_d[ch_sel_q] = 1'b1;
        err_d[ch_sel_q]  = tmo_q;
        rr_ptr_d         = (int'(ch_sel_q) == NUM_CH - 1) ? '0 : ch_sel_q + 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // DRP outputs are registered off the next state so they line up with it.
    sel_oh           = '0;
    sel_oh[ch_sel_d] = 1'b1;
    strobe_st        = (state_d == START_RD) || (state_d == START_WR);
    drpen_d          = strobe_st ? sel_oh : '0;
    drpwe_d          = (state_d == START_WR) ? sel_oh : '0;
    drpaddr_d        = strobe_st ? RMW_ADDR : '0;
    drpdi_d          = (state_d == START_WR) ? data_d : '0;
    busy_d           = (state_d != IDLE);
  end

  always_ff @(posedge freerun_clk_in or posedge gtwiz_drp_reset_in) begin
    if (gtwiz_drp_reset_in) begin
      state_q    <= IDLE;
      ch_sel_q   <= '0;
      mode_sel_q <= 1'b0;
      rr_ptr_q   <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      tmo_q      <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
      drpen_q    <= '0;
      drpwe_q    <= '0;
      drpaddr_q  <= '0;
      drpdi_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_sel_q   <= ch_sel_d;
      mode_sel_q <= mode_sel_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      tmo_q      <= tmo_d;
      done_q     <= done_d;
      err_q      <= err_d;
      drpen_q    <= drpen_d;
      drpwe_q    <= drpwe_d;
      drpaddr_q  <= drpaddr_d;
      drpdi_q    <= drpdi_d;
      busy_q     <= busy_d;
    end
  end

  assign drp_reconfig_done_out = done_q;
  assign drp_err_out           = err_q;
  assign drpen_out             = drpen_q;
  assign drpwe_out             = drpwe_q;
  assign drpaddr_out           = drpaddr_q;
  assign drpdi_out             = drpdi_q;
  assign busy_out              = busy_q;

endmodule
